pipe_stage_reg: RTL

Parametrised pipeline stage register: the general successor to the fixed per-boundary control registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a control bundle and a data bundle across one pipeline boundary with a valid/ready handshake, synchronous flush, and an optional 2-entry skid buffer. The skid buffer registers the upstream ready path and lets a downstream stall propagate one cycle late without losing data. Bubbles always present all-zero control, so a flushed or empty slot can never assert register write or memory write.

---
 rtl/pipe_pkg.sv | 14 +
 rtl/pipe_entry_reg.sv | 24 ++
 rtl/pipe_stage_reg.sv | 95 +++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline stage state encoding and per-boundary control constants
package pipe_pkg;
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } stage_state_t;
  localparam int IF_ID_CTRL_W   = 1;
  localparam int ID_EX_CTRL_W   = 6;
  localparam int EX_MEM_CTRL_W  = 4;
  localparam int MEM_WB_CTRL_W  = 2;
  localparam int CTRL_REG_WRITE_BIT  = 1;
  localparam int CTRL_MEM_TO_REG_BIT = 0;
endpackage

// File: rtl/pipe_entry_reg.sv
// pipe_entry_reg: one {ctrl, data} storage entry with load enable and synchronous clear
module pipe_entry_reg #(
  parameter int CTRL_WIDTH = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  load,
  input  logic [CTRL_WIDTH-1:0] d_ctrl,
  input  logic [DATA_WIDTH-1:0] d_data,
  output logic [CTRL_WIDTH-1:0] q_ctrl,
  output logic [DATA_WIDTH-1:0] q_data
);
  // clear wins over load so reset always leaves a zeroed entry
  always_ff @(posedge clk) begin
    if (clear) begin
      q_ctrl <= '0;
      q_data <= '0;
    end else if (load) begin
      q_ctrl <= d_ctrl;
      q_data <= d_data;
    end
  end
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline boundary register with flush and optional 2-entry skid buffer
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_WIDTH = 2,
  parameter int DATA_WIDTH = 32,
  parameter int SKID       = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy
);
  stage_state_t state, next_state;
  logic in_fire, head_load, skid_load;
  logic [CTRL_WIDTH-1:0] head_ctrl, skid_ctrl;
  logic [DATA_WIDTH-1:0] skid_data;
  assign in_fire = in_valid & in_ready;
  // next state and entry load enables; flush overrides every transfer
  always_comb begin
    next_state = state;
    head_load  = 1'b0;
    skid_load  = 1'b0;
    case (state)
      ST_EMPTY: if (in_fire) begin
        head_load  = 1'b1;
        next_state = ST_FULL;
      end
      ST_FULL: if (out_ready) begin
        head_load  = in_fire;
        next_state = in_fire ? ST_FULL : ST_EMPTY;
      end else if (in_fire) begin
        skid_load  = 1'b1;
        next_state = ST_SKID;
      end
      ST_SKID: if (out_ready) begin
        head_load  = 1'b1;
        next_state = ST_FULL;
      end
      default: next_state = ST_EMPTY;
    endcase
    if (flush) begin
      next_state = ST_EMPTY;
      head_load  = 1'b0;
      skid_load  = 1'b0;
    end
  end
  // state register; reset takes priority over flush
  always_ff @(posedge clk) begin
    state <= reset ? ST_EMPTY : next_state;
  end
  pipe_entry_reg #(.CTRL_WIDTH(CTRL_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_head (
    .clk   (clk),
    .clear (reset),
    .load  (head_load),
    .d_ctrl(state == ST_SKID ? skid_ctrl : in_ctrl),
    .d_data(state == ST_SKID ? skid_data : in_data),
    .q_ctrl(head_ctrl),
    .q_data(out_data)
  );
  generate
    if (SKID != 0) begin : g_skid
      logic in_ready_q;
      pipe_entry_reg #(.CTRL_WIDTH(CTRL_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_skid (
        .clk   (clk),
        .clear (reset),
        .load  (skid_load),
        .d_ctrl(in_ctrl),
        .d_data(in_data),
        .q_ctrl(skid_ctrl),
        .q_data(skid_data)
      );
      // registered ready keeps out_ready off the upstream ready path
      always_ff @(posedge clk) begin
        in_ready_q <= reset ? 1'b1 : (next_state != ST_SKID);
      end
      assign in_ready = in_ready_q;
    end else begin : g_noskid
      assign skid_ctrl = '0;
      assign skid_data = '0;
      assign in_ready  = (state == ST_EMPTY) | out_ready;
    end
  endgenerate
  assign out_valid = state != ST_EMPTY;
  assign occupancy = state;
  assign out_ctrl  = head_ctrl & {CTRL_WIDTH{out_valid}};
endmodule
